// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        R_WB      = 4'd8,
        ADDI_EXEC = 4'd9,
        ADDI_WB   = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        TRAP      = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Dispatch target out of DECODE; anything unrecognised halts the core.
    function automatic state_e decode_next(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_RTYPE:     nxt = EXEC_R;
            OP_LW, OP_SW: nxt = MEM_ADDR;
            OP_BEQ:       nxt = BRANCH;
            OP_J:         nxt = JUMP;
            OP_ADDI:      nxt = ADDI_EXEC;
            default:      nxt = TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle FSM and the datapath.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode_i;
    logic             zero_i;
    logic             mem_ready_i;
    logic             pc_write_o;
    logic             pc_write_cond_o;
    logic             iord_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             ir_write_o;
    logic             mem_to_reg_o;
    logic             reg_dst_o;
    logic             reg_write_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [1:0]       alu_op_o;
    logic [1:0]       pc_source_o;
    logic             trap_o;
    logic [CNT_W-1:0] cycle_count_o;
    logic [CNT_W-1:0] instr_count_o;

    modport master (
        input  opcode_i, zero_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
               ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, pc_source_o, trap_o,
               cycle_count_o, instr_count_o
    );

    modport slave (
        output opcode_i, zero_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
               ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, pc_source_o, trap_o,
               cycle_count_o, instr_count_o
    );
endinterface

// File: rtl/multicycle_control_perf_counters.sv
// Cycle and retired-instruction counters; both wrap silently and hold while frozen.
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_cycle_i,
    input  logic             inc_instr_i,
    input  logic             freeze_i,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instr_count_o
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;

    // Next counter values
    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (freeze_i) begin
            cycle_d = cycle_q;
            instr_d = instr_q;
        end else begin
            if (inc_cycle_i) begin
                cycle_d = cycle_q + ONE;
            end else begin
                cycle_d = cycle_q;
            end
            if (inc_instr_i) begin
                instr_d = instr_q + ONE;
            end else begin
                instr_d = instr_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q <= {CNT_W{1'b0}};
            instr_q <= {CNT_W{1'b0}};
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count_o = cycle_q;
    assign instr_count_o = instr_q;
endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS-subset datapath with a shared memory port.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    multicycle_control_if.master bus
);
    state_e state_q, state_d;
    logic   store_q, store_d;
    logic   retire_s;
    logic   inc_cycle_s;
    logic   freeze_s;

    // State register; store_q remembers lw vs sw so opcode is only looked at in DECODE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
        end
    end

    // Next-state and retire detection
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        retire_s = 1'b0;
        case (state_q)
            IDLE:      state_d = FETCH;
            FETCH: begin
                if (bus.mem_ready_i) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                state_d = decode_next(bus.opcode_i);
                store_d = (bus.opcode_i == OP_SW);
            end
            MEM_ADDR: begin
                if (store_q) begin
                    state_d = MEM_WRITE;
                end else begin
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                if (bus.mem_ready_i) begin
                    state_d = MEM_WB;
                end else begin
                    state_d = MEM_READ;
                end
            end
            MEM_WRITE: begin
                if (bus.mem_ready_i) begin
                    state_d  = FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d  = MEM_WRITE;
                end
            end
            EXEC_R:    state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: begin
                state_d  = FETCH;
                retire_s = 1'b1;
            end
            TRAP:      state_d = TRAP;
            default:   state_d = TRAP;
        endcase
    end

    // Moore output decode; only FETCH looks at mem_ready_i for its load strobes
    always_comb begin
        bus.pc_write_o      = 1'b0;
        bus.pc_write_cond_o = 1'b0;
        bus.iord_o          = 1'b0;
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        bus.ir_write_o      = 1'b0;
        bus.mem_to_reg_o    = 1'b0;
        bus.reg_dst_o       = 1'b0;
        bus.reg_write_o     = 1'b0;
        bus.alu_src_a_o     = 1'b0;
        bus.alu_src_b_o     = SRCB_B;
        bus.alu_op_o        = ALU_ADD;
        bus.pc_source_o     = PCSRC_ALU;
        bus.trap_o          = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_read_o  = 1'b1;
                bus.alu_src_b_o = SRCB_FOUR;
                bus.ir_write_o  = bus.mem_ready_i;
                bus.pc_write_o  = bus.mem_ready_i;
            end
            DECODE:    bus.alu_src_b_o = SRCB_IMM_SH2;
            MEM_ADDR, ADDI_EXEC: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = SRCB_IMM;
            end
            MEM_READ: begin
                bus.iord_o     = 1'b1;
                bus.mem_read_o = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write_o  = 1'b1;
                bus.mem_to_reg_o = 1'b1;
            end
            MEM_WRITE: begin
                bus.iord_o      = 1'b1;
                bus.mem_write_o = 1'b1;
            end
            EXEC_R: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_op_o    = ALU_FUNCT;
            end
            R_WB: begin
                bus.reg_write_o = 1'b1;
                bus.reg_dst_o   = 1'b1;
            end
            ADDI_WB:   bus.reg_write_o = 1'b1;
            BRANCH: begin
                bus.alu_src_a_o     = 1'b1;
                bus.alu_op_o        = ALU_SUB;
                bus.pc_write_cond_o = 1'b1;
                bus.pc_source_o     = PCSRC_ALUOUT;
            end
            JUMP: begin
                bus.pc_write_o  = 1'b1;
                bus.pc_source_o = PCSRC_JUMP;
            end
            TRAP:      bus.trap_o = 1'b1;
            default:   bus.trap_o = 1'b0;
        endcase
    end

    assign inc_cycle_s = (state_q != IDLE) && (state_q != TRAP);
    assign freeze_s    = (state_q == TRAP);

    perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf_counters (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .inc_cycle_i   (inc_cycle_s),
        .inc_instr_i   (retire_s),
        .freeze_i      (freeze_s),
        .cycle_count_o (bus.cycle_count_o),
        .instr_count_o (bus.instr_count_o)
    );
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-cycle control words, latencies and counters against a spec-level model.
module tb_multicycle_control;
    localparam int CNT_W = 8;
    localparam int MOD   = 256;

    localparam int K_IDLE = 0, K_FETCH = 1, K_DECODE = 2, K_ADDR = 3, K_MRD = 4,
                   K_MWB = 5, K_MWR = 6, K_EXR = 7, K_RWB = 8, K_ADDI = 9,
                   K_AWB = 10, K_BEQ = 11, K_J = 12, K_TRAP = 13;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       trap;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
        logic       zero;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   exp_cyc = 0;
    int   exp_ins = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();
    multicycle_control #(.CNT_W(CNT_W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    function automatic ctl_t act();
        ctl_t a;
        a = {bus.pc_write_o, bus.pc_write_cond_o, bus.iord_o, bus.mem_read_o, bus.mem_write_o,
             bus.ir_write_o, bus.mem_to_reg_o, bus.reg_dst_o, bus.reg_write_o, bus.alu_src_a_o,
             bus.alu_src_b_o, bus.alu_op_o, bus.pc_source_o, bus.trap_o};
        return a;
    endfunction

    // Required control word for each phase of an instruction; unlisted strobes are 0.
    function automatic ctl_t want(input int k, input bit rdy);
        ctl_t w;
        w = '0;
        case (k)
            K_FETCH:  begin w.mrd = 1'b1; w.srcb = 2'd1; w.irw = rdy; w.pcw = rdy; end
            K_DECODE: w.srcb = 2'd3;
            K_ADDR:   begin w.srca = 1'b1; w.srcb = 2'd2; end
            K_MRD:    begin w.iord = 1'b1; w.mrd = 1'b1; end
            K_MWB:    begin w.rw = 1'b1; w.m2r = 1'b1; end
            K_MWR:    begin w.iord = 1'b1; w.mwr = 1'b1; end
            K_EXR:    begin w.srca = 1'b1; w.aluop = 2'd2; end
            K_RWB:    begin w.rw = 1'b1; w.rdst = 1'b1; end
            K_ADDI:   begin w.srca = 1'b1; w.srcb = 2'd2; end
            K_AWB:    w.rw = 1'b1;
            K_BEQ:    begin w.srca = 1'b1; w.aluop = 2'd1; w.pcwc = 1'b1; w.pcsrc = 2'd1; end
            K_J:      begin w.pcw = 1'b1; w.pcsrc = 2'd2; end
            K_TRAP:   w.trap = 1'b1;
            default:  w = '0;
        endcase
        return w;
    endfunction

    function automatic int lat_of(input logic [5:0] op, input int fw, input int mw);
        case (op)
            6'b100011: return 5 + fw + mw;
            6'b101011: return 4 + fw + mw;
            6'b000100, 6'b000010: return 3 + fw;
            default:   return 4 + fw;
        endcase
    endfunction

    task automatic chk_ctl(input string nm, input int k, input bit rdy);
        ctl_t e, a;
        e = want(k, rdy);
        a = act();
        n_chk++;
        if (a !== e) $display("FAIL %s: got ctl %h, want %h (t=%0t)", nm, a, e, $time);
        else n_pass++;
    endtask

    task automatic chk_val(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, exp, $time);
        else n_pass++;
    endtask

    task automatic chk_cnt(input string nm);
        chk_val({nm, "_cycles"}, int'(bus.cycle_count_o), exp_cyc);
        chk_val({nm, "_instrs"}, int'(bus.instr_count_o), exp_ins);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: drive ready, check the word, advance the model's cycle count, cross the edge.
    task automatic step(input string nm, input int k, input bit rdy);
        bus.mem_ready_i = rdy;
        #1;
        chk_ctl(nm, k, rdy);
        if (k != K_IDLE && k != K_TRAP) exp_cyc = (exp_cyc + 1) % MOD;
        tick();
    endtask

    task automatic fetch_decode(input logic [5:0] op, input int fw);
        for (int i = 0; i < fw; i++) step("fetch_wait", K_FETCH, 1'b0);
        step("fetch", K_FETCH, 1'b1);
        bus.opcode_i = op;
        step("decode", K_DECODE, 1'($urandom));
        bus.opcode_i = op ^ 6'b001000;  // later opcode changes must be ignored
    endtask

    // Run one legal instruction from FETCH back to the next FETCH.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic zero, input int exp_lat);
        int c0;
        c0 = int'(bus.cycle_count_o);
        bus.zero_i = zero;
        fetch_decode(op, fw);
        case (op)
            6'b000000: begin step("exec_r", K_EXR, 1'($urandom)); step("r_wb", K_RWB, 1'($urandom)); end
            6'b001000: begin step("addi", K_ADDI, 1'($urandom)); step("addi_wb", K_AWB, 1'($urandom)); end
            6'b000100: step("beq", K_BEQ, 1'($urandom));
            6'b000010: step("jump", K_J, 1'($urandom));
            6'b100011: begin
                step("lw_addr", K_ADDR, 1'($urandom));
                for (int i = 0; i < mw; i++) step("lw_wait", K_MRD, 1'b0);
                step("lw_read", K_MRD, 1'b1);
                step("lw_wb", K_MWB, 1'($urandom));
            end
            default: begin
                step("sw_addr", K_ADDR, 1'($urandom));
                for (int i = 0; i < mw; i++) step("sw_wait", K_MWR, 1'b0);
                step("sw_write", K_MWR, 1'b1);
            end
        endcase
        exp_ins = (exp_ins + 1) % MOD;
        chk_val("latency", (int'(bus.cycle_count_o) - c0 + MOD) % MOD, exp_lat % MOD);
        chk_cnt("retire");
    endtask

    task automatic do_reset_midcycle();
        #2;
        rst_n = 1'b0;
        #1;
        exp_cyc = 0;
        exp_ins = 0;
        chk_ctl("reset_async_outputs", K_IDLE, 1'b0);
        chk_cnt("reset_async");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step("idle_after_reset", K_IDLE, 1'b1);
    endtask

    vec_t tbl[9];
    logic [5:0] legal[6];

    initial begin
        tbl[0] = '{6'b000000, 0, 0, 1'b0, 4};
        tbl[1] = '{6'b100011, 0, 2, 1'b0, 7};
        tbl[2] = '{6'b101011, 0, 1, 1'b0, 5};
        tbl[3] = '{6'b000100, 0, 0, 1'b1, 3};
        tbl[4] = '{6'b000100, 0, 0, 1'b0, 3};
        tbl[5] = '{6'b000010, 0, 0, 1'b0, 3};
        tbl[6] = '{6'b001000, 1, 0, 1'b0, 5};
        tbl[7] = '{6'b100011, 0, 0, 1'b1, 5};
        tbl[8] = '{6'b101011, 2, 0, 1'b0, 6};
        legal  = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

        bus.opcode_i    = 6'b000000;
        bus.zero_i      = 1'b0;
        bus.mem_ready_i = 1'b1;
        #1;
        chk_ctl("in_reset", K_IDLE, 1'b1);
        chk_cnt("in_reset");
        #22;
        rst_n = 1'b1;
        step("idle", K_IDLE, 1'b1);

        for (int i = 0; i < 9; i++) run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].zero, tbl[i].lat);

        // Random program long enough to wrap both 8-bit counters.
        for (int i = 0; i < 270; i++) begin
            logic [5:0] op;
            int fw, mw;
            op = legal[$urandom_range(0, 5)];
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 3);
            run_instr(op, fw, mw, 1'($urandom), lat_of(op, fw, mw));
        end

        // Illegal opcode: halt with frozen counters.
        fetch_decode(6'b111111, 1);
        for (int i = 0; i < 20; i++) begin
            bus.opcode_i = 6'($urandom);
            step("trap", K_TRAP, 1'($urandom));
            chk_cnt("trap_frozen");
        end
        do_reset_midcycle();

        // Reset while a store is waiting on memory.
        fetch_decode(6'b101011, 0);
        step("sw_addr", K_ADDR, 1'b0);
        step("sw_wait", K_MWR, 1'b0);
        bus.mem_ready_i = 1'b0;
        #1;
        chk_ctl("sw_pending", K_MWR, 1'b0);
        do_reset_midcycle();
        run_instr(6'b000000, 0, 0, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
